kirby_anim_sequencer: RTL

Sequences Kirby's sprite animation by generating the action index and in-action frame index consumed by the Kirby frame-geometry lookup. It advances frames on the per-frame tick and plays each action for its fixed frame count. Looping actions wrap; the one-shot action plays once and then returns to standing. It sits between the game-logic/keyboard control path and the sprite addressing/draw logic.

---
 rtl/kirby_anim_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/kirby_anim_sequencer.sv
// kirby_anim_sequencer
// Produces the action index and in-action frame index for Kirby's sprite
// lookup. Frames advance every FRAME_HOLD frame ticks. Stand (2 frames) and
// walk (10 frames) loop; inhale (10 frames) plays once and returns to stand.
//
// Ports:
//   Clk                        system clock, rising edge
//   Reset                      asynchronous active-high reset
//   frame_tick                 one-cycle pulse per video frame
//   req_valid / req_action     action change request (held until req_ready)
//   req_ready                  high when a request can be accepted
//   character_action_idx       current action (0 stand, 1 walk, 2 inhale)
//   character_action_frame_idx current frame within the action
//   frame_changed              one-cycle pulse when either index changes
//   anim_done                  one-cycle pulse when inhale finishes
//
// state     | meaning
// S_LOOP    | stand or walk playing, wrapping; requests accepted
// S_ONESHOT | inhale playing once; requests ignored

module kirby_anim_sequencer #(
    parameter int FRAME_HOLD = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       req_valid,
    input  logic [2:0] req_action,
    output logic       req_ready,
    output logic [2:0] character_action_idx,
    output logic [3:0] character_action_frame_idx,
    output logic       frame_changed,
    output logic       anim_done
);

    typedef enum logic {S_LOOP = 1'b0, S_ONESHOT = 1'b1} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(FRAME_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] action_q, action_d;
    logic [3:0] frame_q, frame_d;
    logic [3:0] hold_q, hold_d;
    logic       frame_changed_q, frame_changed_d;
    logic       anim_done_q, anim_done_d;

    logic       accept;
    logic [2:0] req_eff;
    logic [3:0] loop_last;

    assign accept    = req_valid && (state_q == S_LOOP);
    // Out-of-range requests fall back to standing.
    assign req_eff   = (req_action >= 3'd3) ? 3'd0 : req_action;
    // Only stand and walk are ever looped.
    assign loop_last = (action_q == 3'd1) ? 4'd9 : 4'd1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q         <= S_LOOP;
            action_q        <= 3'd0;
            frame_q         <= 4'd0;
            hold_q          <= 4'd0;
            frame_changed_q <= 1'b0;
            anim_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            action_q        <= action_d;
            frame_q         <= frame_d;
            hold_q          <= hold_d;
            frame_changed_q <= frame_changed_d;
            anim_done_q     <= anim_done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        action_d        = action_q;
        frame_d         = frame_q;
        hold_d          = hold_q;
        frame_changed_d = 1'b0;
        anim_done_d     = 1'b0;

        if (accept) begin
            // An accepted request always consumes a coincident tick, even
            // when it names the action already playing.
            if (req_eff != action_q) begin
                action_d        = req_eff;
                frame_d         = 4'd0;
                hold_d          = 4'd0;
                frame_changed_d = 1'b1;
                state_d         = (req_eff == 3'd2) ? S_ONESHOT : S_LOOP;
            end
        end else if (frame_tick) begin
            if (hold_q < HOLD_LAST) begin
                hold_d = hold_q + 4'd1;
            end else begin
                hold_d          = 4'd0;
                frame_changed_d = 1'b1;
                if (state_q == S_ONESHOT) begin
                    if (frame_q == 4'd9) begin
                        action_d    = 3'd0;
                        frame_d     = 4'd0;
                        state_d     = S_LOOP;
                        anim_done_d = 1'b1;
                    end else begin
                        frame_d = frame_q + 4'd1;
                    end
                end else begin
                    frame_d = (frame_q >= loop_last) ? 4'd0 : frame_q + 4'd1;
                end
            end
        end
    end

    always_comb begin
        req_ready                  = (state_q == S_LOOP);
        character_action_idx       = action_q;
        character_action_frame_idx = frame_q;
        frame_changed              = frame_changed_q;
        anim_done                  = anim_done_q;
    end

endmodule
